sd_pcm_decoder: RTL and testbench
=================================

// Module: sd_pcm_decoder
// PURPOSE
//  1-bit sigma-delta bitstream decoder: 2nd-order CIC (sinc^2) decimator recovering 10-bit
//  excess-2^9 PCM, the inverse of the 10-bit sigma-delta DAC. Input comes from an external
//  comparator/RC loop or from a loopback of a DAC output pin. The output feeds the sound
//  capture path and the DAC self-test. Stream density p decodes to round-free p*1024, clipped to 1023.
// PARAMETERS
//  DECIM_LOG2  5  decimation ratio R = 2**DECIM_LOG2; legal range 5..8
//  SYNC_EN     1  1: 2-flop synchronizer on SdIn (async source); 0: SdIn used directly
// PORTS
//  Clk       in   1   system clock
//  Reset     in   1   asynchronous, active-high reset
//  Ce        in   1   bitstream sample enable; all filter state frozen when 0
//  SdIn      in   1   sigma-delta bitstream (1 = high density)
//  PcmOut    out  10  decoded sample, excess-2^9 (512 = mid-scale)
//  PcmValid  out  1   one-Clk pulse: new PcmOut this cycle
//  PcmSat    out  1   PcmOut was clipped (qualified by PcmValid, held with PcmOut)
// BEHAVIOUR
//  Reset: PcmOut=0, PcmValid=0, PcmSat=0, integrators/combs/counter=0, sync flops=0, state=WARM0.
//  Sync: when SYNC_EN=1, s = SdIn delayed 2 Clk; flops clock every Clk, ignoring Ce.
//  Width: W = 2*DECIM_LOG2+1. All integrator/comb arithmetic is modulo 2^W (wrap is intended,
//   never saturate internally). Max comb result R^2 fits in W bits.
//  Each Clk with Ce=1: I1n = I1 + s; I2n = I2 + I1n; cnt <= cnt+1 (mod R).
//  Decimation event = Ce=1 and cnt==R-1. On that edge:
//   d1 = I2n - Z1; Z1 <= I2n; d2 = d1 - Z2; Z2 <= d1;
//   v = d2 >> (2*DECIM_LOG2-10); PcmOut <= (v>1023) ? 1023 : v; PcmSat <= (v>1023).
//   PcmValid <= 1 for exactly one Clk, only if state==RUN; otherwise PcmOut/PcmSat still update
//   but PcmValid stays 0.
//  State machine (advances only on decimation events): WARM0 -> WARM1 -> RUN; RUN holds.
//   The first two frames (comb pipeline fill) are never flagged valid.
//  Latency: PcmOut/PcmValid change on the decimation-event edge; PcmValid visible the cycle
//   after that edge, together with the new PcmOut. SdIn-to-integrator: 2 Clk (SYNC_EN=1) or 0.
//  Rate: with Ce=1 continuously, PcmValid every R Clk; with Ce duty 1/N, every R*N Clk.
//  Ce=0: no state changes; PcmValid pulse from a previous event still drops after one Clk.
//  PcmOut/PcmSat hold between events. No back-pressure: consumer must take the sample on PcmValid.
//  Reset mid-frame: immediate clear of all outputs and state; warm-up restarts from WARM0.
//  Exact results: a periodic pattern whose period divides R gives d2 = R^2*density exactly.
// TESTING
//  1 Reset asserted mid-frame (cnt=17) -> PcmOut=0, PcmValid=0 that cycle; next 2 events give no
//    PcmValid; 3rd event valid.
//  2 DECIM_LOG2=5, Ce=1, SdIn=1 constant -> PcmValid every 32 Clk from 3rd event; PcmOut=1023,
//    PcmSat=1. SdIn=0 constant -> PcmOut=0, PcmSat=0.
//  3 SdIn pattern 1010... -> PcmOut=512; 1000... -> 256; 1110... -> 768; PcmSat=0 in all cases.
//  4 Loopback: 10-bit sigma-delta DAC (same Clk) driven with 700 -> after warm-up, every PcmOut
//    within 700+-8; mean of 16 consecutive outputs within +-1 of 700.
//  5 Ce high 1 Clk in 4, pattern 1010 (on Ce cycles) -> PcmValid every 128 Clk, PcmOut=512;
//    holding Ce=0 for 500 Clk -> no PcmValid, PcmOut unchanged.
//  6 DECIM_LOG2=8, SdIn=1 -> PcmOut=1023 (v=1024 clipped), PcmSat=1; 1010 -> 512; W=17 wrap
//    of integrators after >65536 samples causes no glitch in PcmOut.

Source files
------------

// File: rtl/sd_pcm_decoder.sv
// sd_pcm_decoder
// Second-order CIC (sinc^2) decimator that turns a 1-bit sigma-delta bitstream
// into 10-bit excess-512 PCM. A density of p decodes to p*1024, clipped to 1023.
//
// Ports
//   Clk       in   1   system clock
//   Reset     in   1   asynchronous, active-high reset
//   Ce        in   1   bitstream sample enable; filter state frozen when low
//   SdIn      in   1   sigma-delta bitstream (1 = high density)
//   PcmOut    out  10  decoded sample, excess-512 (512 = mid-scale)
//   PcmValid  out  1   one-cycle pulse marking a new PcmOut
//   PcmSat    out  1   PcmOut was clipped; held alongside PcmOut
//
// Parameters
//   DECIM_LOG2  decimation ratio R = 2**DECIM_LOG2, legal range 5..8
//   SYNC_EN     1: two-flop synchronizer on SdIn, 0: SdIn used directly
module sd_pcm_decoder #(
  parameter int unsigned DECIM_LOG2 = 5,
  parameter bit          SYNC_EN    = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Ce,
  input  logic       SdIn,
  output logic [9:0] PcmOut,
  output logic       PcmValid,
  output logic       PcmSat
);

  // Accumulator width: R^2 (the largest comb result) must fit.
  localparam int unsigned W     = 2 * DECIM_LOG2 + 1;
  localparam int unsigned CW    = DECIM_LOG2;
  localparam int unsigned SHIFT = 2 * DECIM_LOG2 - 10;

  typedef enum logic [1:0] {
    ST_WARM0 = 2'd0,
    ST_WARM1 = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic [W-1:0]  r_i1;
  logic [W-1:0]  r_i2;
  logic [W-1:0]  r_z1;
  logic [W-1:0]  r_z2;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_pcm;
  logic          r_valid;
  logic          r_sat;
  state_t        r_state;

  logic          w_s;
  logic          w_event;
  logic [W-1:0]  w_i1n;
  logic [W-1:0]  w_i2n;
  logic [W-1:0]  w_d1;
  logic [W-1:0]  w_d2;
  logic [W-1:0]  w_v;
  logic          w_sat;
  logic [9:0]    w_pcm;

  // Synchronizer runs every clock regardless of Ce.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= SdIn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = SYNC_EN ? r_sync2 : SdIn;

  // Integrators and combs are modulo 2^W; wrap is harmless because the
  // true comb output never exceeds R^2.
  assign w_i1n   = r_i1 + W'(w_s);
  assign w_i2n   = r_i2 + w_i1n;
  assign w_d1    = w_i2n - r_z1;
  assign w_d2    = w_d1 - r_z2;
  assign w_v     = w_d2 >> SHIFT;
  assign w_sat   = (w_v > W'(1023));
  assign w_pcm   = w_sat ? 10'd1023 : w_v[9:0];
  assign w_event = Ce && (&r_cnt);

  // Filter datapath, output registers and warm-up state machine.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_i1    <= '0;
      r_i2    <= '0;
      r_z1    <= '0;
      r_z2    <= '0;
      r_cnt   <= '0;
      r_pcm   <= 10'd0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
      r_state <= ST_WARM0;
    end else begin
      r_valid <= 1'b0;
      if (Ce) begin
        r_i1  <= w_i1n;
        r_i2  <= w_i2n;
        r_cnt <= r_cnt + CW'(1);
        if (w_event) begin
          r_z1  <= w_i2n;
          r_z2  <= w_d1;
          r_pcm <= w_pcm;
          r_sat <= w_sat;
          // First two frames only fill the comb pipeline.
          r_valid <= (r_state == ST_RUN);
          case (r_state)
            ST_WARM0: r_state <= ST_WARM1;
            ST_WARM1: r_state <= ST_RUN;
            default:  r_state <= ST_RUN;
          endcase
        end
      end
    end
  end

  assign PcmOut   = r_pcm;
  assign PcmValid = r_valid;
  assign PcmSat   = r_sat;

endmodule

// File: tb/tb_sd_pcm_decoder.sv
// tb_sd_pcm_decoder
// Drives two decoders (R=32 with synchronizer, R=256 without) from a shared
// bitstream and compares them against a triangular-FIR reference model.
`timescale 1ns/1ps
module tb_sd_pcm_decoder;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Ce;
  logic       SdIn;
  logic [9:0] pcm5, pcm8;
  logic       val5, val8, sat5, sat8;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: sample history per instance and frame bookkeeping.
  int rr [2] = '{32, 256};
  int sh [2] = '{0, 6};
  int samp [2][512];
  int ptr [2];
  int cnt [2];
  int nev [2];
  int exp_out [2];
  bit exp_sat [2];
  bit exp_valid [2];
  bit dly0, dly1;

  logic [3:0] pats [3] = '{4'b1010, 4'b1000, 4'b1110};
  int         want [3] = '{512, 256, 768};

  always #5 Clk = ~Clk;

  sd_pcm_decoder #(.DECIM_LOG2(5), .SYNC_EN(1'b1)) dut5 (
    .Clk(Clk), .Reset(Reset), .Ce(Ce), .SdIn(SdIn),
    .PcmOut(pcm5), .PcmValid(val5), .PcmSat(sat5)
  );

  sd_pcm_decoder #(.DECIM_LOG2(8), .SYNC_EN(1'b0)) dut8 (
    .Clk(Clk), .Reset(Reset), .Ce(Ce), .SdIn(SdIn),
    .PcmOut(pcm8), .PcmValid(val8), .PcmSat(sat8)
  );

  task automatic model_reset;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 512; k++) samp[m][k] = 0;
      ptr[m] = 0; cnt[m] = 0; nev[m] = 0;
      exp_out[m] = 0; exp_sat[m] = 1'b0; exp_valid[m] = 1'b0;
    end
    dly0 = 1'b0; dly1 = 1'b0;
  endtask

  // sinc^2 response: triangular weights 1..R..1 over the last 2R-1 samples.
  function automatic int conv(input int m);
    int acc;
    int r;
    acc = 0;
    r = rr[m];
    for (int j = 0; j < 2 * r - 1; j++)
      acc += ((j < r) ? (j + 1) : (2 * r - 1 - j)) * samp[m][(ptr[m] - j) & 511];
    return acc;
  endfunction

  // One clock of stimulus with the model advanced at the same edge.
  task automatic step(input bit ce, input bit sd);
    bit s;
    int v;
    Ce = ce;
    SdIn = sd;
    @(posedge Clk);
    for (int m = 0; m < 2; m++) begin
      exp_valid[m] = 1'b0;
      s = (m == 0) ? dly1 : sd;
      if (ce) begin
        ptr[m] = (ptr[m] + 1) & 511;
        samp[m][ptr[m]] = s ? 1 : 0;
        cnt[m]++;
        if (cnt[m] == rr[m]) begin
          cnt[m] = 0;
          nev[m]++;
          v = conv(m) >> sh[m];
          exp_sat[m] = (v > 1023);
          exp_out[m] = exp_sat[m] ? 1023 : v;
          exp_valid[m] = (nev[m] >= 3);
        end
      end
    end
    dly1 = dly0;
    dly0 = sd;
    cyc++;
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    Ce = 1'b0;
    SdIn = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({val5, sat5, pcm5} !== 12'd0) begin
      errors++;
      $display("FAIL reset_r32 got v=%0b s=%0b pcm=%0d expected 0/0/0", val5, sat5, pcm5);
    end
    checks++;
    if ({val8, sat8, pcm8} !== 12'd0) begin
      errors++;
      $display("FAIL reset_r256 got v=%0b s=%0b pcm=%0d expected 0/0/0", val8, sat8, pcm8);
    end
  endtask

  task automatic test_reset_midframe;
    int nval;
    int first;
    do_reset();
    for (int i = 0; i < 3 * 32 + 17; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if ({val5, sat5, pcm5} !== {exp_valid[0], exp_sat[0], 10'(exp_out[0])}) begin
        errors++;
        $display("FAIL midrst_pre cyc=%0d got v=%0b s=%0b pcm=%0d expected v=%0b s=%0b pcm=%0d",
                 cyc, val5, sat5, pcm5, exp_valid[0], exp_sat[0], exp_out[0]);
      end
    end
    Reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({val5, sat5, pcm5} !== 12'd0) begin
      errors++;
      $display("FAIL midrst_clear got v=%0b s=%0b pcm=%0d expected 0/0/0", val5, sat5, pcm5);
    end
    @(posedge Clk);
    #1 Reset = 1'b0;
    nval = 0;
    first = -1;
    for (int i = 0; i < 3 * 32; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if ({val5, sat5, pcm5} !== {exp_valid[0], exp_sat[0], 10'(exp_out[0])}) begin
        errors++;
        $display("FAIL midrst_post cyc=%0d got v=%0b s=%0b pcm=%0d expected v=%0b s=%0b pcm=%0d",
                 cyc, val5, sat5, pcm5, exp_valid[0], exp_sat[0], exp_out[0]);
      end
      if (val5 === 1'b1) begin
        nval++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (nval != 1 || first != 95) begin
      errors++;
      $display("FAIL midrst_warmup got valids=%0d first_at=%0d expected 1 at 95", nval, first);
    end
  endtask

  task automatic test_constant;
    int nval;
    int last;
    int seen;
    do_reset();
    nval = 0;
    last = -1;
    for (int i = 0; i < 8 * 32; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if ({val5, sat5, pcm5} !== {exp_valid[0], exp_sat[0], 10'(exp_out[0])}) begin
        errors++;
        $display("FAIL const1_model cyc=%0d got v=%0b s=%0b pcm=%0d expected v=%0b s=%0b pcm=%0d",
                 cyc, val5, sat5, pcm5, exp_valid[0], exp_sat[0], exp_out[0]);
      end
      if (val5 === 1'b1) begin
        nval++;
        checks++;
        if (pcm5 !== 10'd1023 || sat5 !== 1'b1) begin
          errors++;
          $display("FAIL const1_value got pcm=%0d sat=%0b expected 1023/1", pcm5, sat5);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 32) begin
            errors++;
            $display("FAIL const1_rate got gap=%0d expected 32", cyc - last);
          end
        end
        last = cyc;
      end
    end
    checks++;
    if (nval != 6) begin
      errors++;
      $display("FAIL const1_count got %0d expected 6", nval);
    end
    seen = 0;
    for (int i = 0; i < 6 * 32; i++) begin
      step(1'b1, 1'b0);
      if (val5 === 1'b1) begin
        seen++;
        if (seen > 2) begin
          checks++;
          if (pcm5 !== 10'd0 || sat5 !== 1'b0) begin
            errors++;
            $display("FAIL const0_value got pcm=%0d sat=%0b expected 0/0", pcm5, sat5);
          end
        end
      end
    end
  endtask

  task automatic test_patterns;
    int seen;
    logic [3:0] pat;
    for (int p = 0; p < 3; p++) begin
      pat = pats[p];
      seen = 0;
      for (int i = 0; i < 6 * 32; i++) begin
        step(1'b1, pat[3 - (i % 4)]);
        checks++;
        if ({val5, sat5, pcm5} !== {exp_valid[0], exp_sat[0], 10'(exp_out[0])}) begin
          errors++;
          $display("FAIL pattern_model p=%0d cyc=%0d got v=%0b s=%0b pcm=%0d expected v=%0b s=%0b pcm=%0d",
                   p, cyc, val5, sat5, pcm5, exp_valid[0], exp_sat[0], exp_out[0]);
        end
        if (val5 === 1'b1) begin
          seen++;
          if (seen > 2) begin
            checks++;
            if (pcm5 !== 10'(want[p]) || sat5 !== 1'b0) begin
              errors++;
              $display("FAIL pattern_value p=%0d got pcm=%0d sat=%0b expected %0d/0", p, pcm5, sat5, want[p]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
      checks++;
      if ({val5, sat5, pcm5} !== {exp_valid[0], exp_sat[0], 10'(exp_out[0])}) begin
        errors++;
        $display("FAIL random_r32 cyc=%0d got v=%0b s=%0b pcm=%0d expected v=%0b s=%0b pcm=%0d",
                 cyc, val5, sat5, pcm5, exp_valid[0], exp_sat[0], exp_out[0]);
      end
      checks++;
      if ({val8, sat8, pcm8} !== {exp_valid[1], exp_sat[1], 10'(exp_out[1])}) begin
        errors++;
        $display("FAIL random_r256 cyc=%0d got v=%0b s=%0b pcm=%0d expected v=%0b s=%0b pcm=%0d",
                 cyc, val8, sat8, pcm8, exp_valid[1], exp_sat[1], exp_out[1]);
      end
    end
  endtask

  task automatic test_loopback;
    int acc;
    bit sd;
    int nval;
    int sum;
    do_reset();
    acc = 0;
    nval = 0;
    sum = 0;
    for (int i = 0; i < 20 * 32; i++) begin
      acc += 700;
      sd = (acc >= 1024);
      if (sd) acc -= 1024;
      step(1'b1, sd);
      checks++;
      if ({val5, sat5, pcm5} !== {exp_valid[0], exp_sat[0], 10'(exp_out[0])}) begin
        errors++;
        $display("FAIL loop_model cyc=%0d got v=%0b s=%0b pcm=%0d expected v=%0b s=%0b pcm=%0d",
                 cyc, val5, sat5, pcm5, exp_valid[0], exp_sat[0], exp_out[0]);
      end
      if (val5 === 1'b1) begin
        checks++;
        if (int'(pcm5) < 692 || int'(pcm5) > 708) begin
          errors++;
          $display("FAIL loop_range got pcm=%0d expected 692..708", pcm5);
        end
        if (nval < 16) sum += int'(pcm5);
        nval++;
      end
    end
    checks++;
    if (nval < 16 || sum < 700 * 16 - 16 || sum > 700 * 16 + 16) begin
      errors++;
      $display("FAIL loop_mean got sum16=%0d over %0d outputs expected %0d+-16", sum, nval, 700 * 16);
    end
  endtask

  task automatic test_ce_gated;
    int seen;
    int last;
    logic [9:0] held;
    do_reset();
    seen = 0;
    last = -1;
    for (int i = 0; i < 8 * 32 * 4; i++) begin
      step((i % 4) == 0, ((i / 4) % 2) == 0);
      checks++;
      if ({val5, sat5, pcm5} !== {exp_valid[0], exp_sat[0], 10'(exp_out[0])}) begin
        errors++;
        $display("FAIL cegate_model cyc=%0d got v=%0b s=%0b pcm=%0d expected v=%0b s=%0b pcm=%0d",
                 cyc, val5, sat5, pcm5, exp_valid[0], exp_sat[0], exp_out[0]);
      end
      if (val5 === 1'b1) begin
        seen++;
        if (last >= 0) begin
          checks++;
          if (cyc - last != 128) begin
            errors++;
            $display("FAIL cegate_rate got gap=%0d expected 128", cyc - last);
          end
        end
        last = cyc;
        if (seen > 2) begin
          checks++;
          if (pcm5 !== 10'd512 || sat5 !== 1'b0) begin
            errors++;
            $display("FAIL cegate_value got pcm=%0d sat=%0b expected 512/0", pcm5, sat5);
          end
        end
      end
    end
    held = pcm5;
    for (int i = 0; i < 500; i++) begin
      step(1'b0, $urandom_range(0, 1) == 1);
      checks++;
      if (val5 !== 1'b0 || pcm5 !== held) begin
        errors++;
        $display("FAIL cehold cyc=%0d got v=%0b pcm=%0d expected 0 and %0d", cyc, val5, pcm5, held);
      end
    end
  endtask

  task automatic test_decim8;
    int seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 50 * 256; i++) begin
      step(1'b1, (i < 6 * 256) ? 1'b1 : (i % 2 == 0));
      checks++;
      if ({val8, sat8, pcm8} !== {exp_valid[1], exp_sat[1], 10'(exp_out[1])}) begin
        errors++;
        $display("FAIL r256_model cyc=%0d got v=%0b s=%0b pcm=%0d expected v=%0b s=%0b pcm=%0d",
                 cyc, val8, sat8, pcm8, exp_valid[1], exp_sat[1], exp_out[1]);
      end
      if (val8 === 1'b1) begin
        seen++;
        checks++;
        if (seen <= 4) begin
          if (pcm8 !== 10'd1023 || sat8 !== 1'b1) begin
            errors++;
            $display("FAIL r256_sat got pcm=%0d sat=%0b expected 1023/1", pcm8, sat8);
          end
        end else if (seen > 6) begin
          if (pcm8 !== 10'd512 || sat8 !== 1'b0) begin
            errors++;
            $display("FAIL r256_half got pcm=%0d sat=%0b expected 512/0", pcm8, sat8);
          end
        end else begin
          checks--;
        end
      end
    end
    checks++;
    if (seen != 48) begin
      errors++;
      $display("FAIL r256_count got %0d expected 48", seen);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Ce = 1'b0;
    SdIn = 1'b0;
    test_reset();
    test_reset_midframe();
    test_constant();
    test_patterns();
    test_random();
    test_loopback();
    test_ce_gated();
    test_decim8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
